// File: rtl/cache_mem_pkg.sv
// Shared types and defaults for the main memory responder.
// The fill-value helper forms the miss word as the pattern XOR the address.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int          DEF_ADDR_WIDTH   = 11;
  localparam int          DEF_DATA_WIDTH   = 11;
  localparam int          DEF_LATENCY      = 4;
  localparam logic [31:0] DEF_MISS_PATTERN = 32'hCAFEBABE;

  // The caller truncates the result to its data width, so the pattern and the address
  // are both zero-extended here.
  function automatic logic [63:0] fill_value(input logic [31:0] pattern,
                                             input logic [63:0] addr);
    return {32'b0, pattern} ^ addr;
  endfunction

endpackage

// File: rtl/mem_array_direct.sv
// Word storage plus one written bit per word, with a single shared read/write address.
// The written bits clear on reset. The array contents are kept through reset.
module mem_array_direct #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_written
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      written_q;
  logic [DEPTH-1:0]      written_d;

  always_comb begin
    written_d = written_q;
    if (wr_en) begin
      written_d[addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      written_q <= '0;
    end else begin
      written_q <= written_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rd_data    = mem_q[addr];
  assign rd_written = written_q[addr];

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency memory responder (IDLE -> WAIT -> RESP), one request in flight.
// Define MAIN_MEMORY_WRITE_EN to add backing storage and writes; otherwise every request reads the fill value.
module main_memory_responder
  import cache_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int          DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int          LATENCY      = DEF_LATENCY,
  parameter logic [31:0] MISS_PATTERN = DEF_MISS_PATTERN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_write
);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_write_q, resp_write_d;
  logic [DATA_WIDTH-1:0] fill_word;

  assign fill_word = DATA_WIDTH'(fill_value(MISS_PATTERN, 64'(addr_q)));

`ifdef MAIN_MEMORY_WRITE_EN
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_written;

  mem_array_direct #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (mem_wr_en),
    .addr       (addr_q),
    .wdata      (wdata_q),
    .rd_data    (rd_data),
    .rd_written (rd_written)
  );
`else
  logic unused_inputs;
  assign unused_inputs = ^{req_write, req_wdata};
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_write_d = resp_write_q;
`ifdef MAIN_MEMORY_WRITE_EN
    write_d      = write_q;
    wdata_d      = wdata_q;
    mem_wr_en    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = 8'(LATENCY - 1);
          state_d = WAIT;
`ifdef MAIN_MEMORY_WRITE_EN
          write_d = req_write;
          wdata_d = req_wdata;
`endif
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_write_d = 1'b0;
          resp_data_d  = fill_word;
`ifdef MAIN_MEMORY_WRITE_EN
          if (write_q) begin
            mem_wr_en    = 1'b1;
            resp_data_d  = wdata_q;
            resp_write_d = 1'b1;
          end else if (rd_written) begin
            resp_data_d  = rd_data;
          end
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drops any in-flight request. The address register is left as it is,
  // because nothing reads it in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_write_q <= 1'b0;
`ifdef MAIN_MEMORY_WRITE_EN
      write_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_write_q <= resp_write_d;
`ifdef MAIN_MEMORY_WRITE_EN
      write_q      <= write_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
`ifdef MAIN_MEMORY_WRITE_EN
    wdata_q <= wdata_d;
`endif
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_write = resp_write_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed testbench for main_memory_responder at default parameters (LATENCY=4).
// Miss word = 0x2BE XOR address; the write scenarios follow MAIN_MEMORY_WRITE_EN.
module tb_main_memory_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_addr;
  logic        req_write;
  logic [10:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [10:0] resp_data;
  logic        resp_write;

  int checks = 0;
  int passes = 0;

  main_memory_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_write (resp_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a request at a falling edge and returns just after the rising edge that accepts it.
  task automatic issue_req(input logic [10:0] addr, input logic wr, input logic [10:0] wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); else passes++;
    checks++; if (resp_data !== 11'h000) $display("[TB] FAIL reset_resp_data: got %h expected 000", resp_data); else passes++;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); else passes++;
    rst = 1'b1;
  endtask

  task automatic test_unwritten_read();
    bit ok;
    issue_req(11'h005, 1'b0, 11'h000);
    ok = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid !== (k == 4)) ok = 1'b0;
    end
    checks++; if (!ok) $display("[TB] FAIL read_latency: resp_valid timing wrong, now %b expected rise after 4 edges", resp_valid); else passes++;
    checks++; if (resp_data !== 11'h2BB) $display("[TB] FAIL read_miss_data: got %h expected 2bb", resp_data); else passes++;
    checks++; if (resp_write !== 1'b0) $display("[TB] FAIL read_resp_write: got %b expected 0", resp_write); else passes++;
    handshake();
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL read_release: valid %b ready %b expected 0 1", resp_valid, req_ready); else passes++;
  endtask

  task automatic test_backpressure();
    bit got;
    bit ok;
    issue_req(11'h00A, 1'b0, 11'h000);
    wait_resp(got);
    checks++; if (!got) $display("[TB] FAIL bp_resp_timeout: got no response expected resp_valid"); else passes++;
    req_valid = 1'b1;
    req_addr  = 11'h7FF;
    req_write = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== 11'h2B4 || req_ready !== 1'b0) ok = 1'b0;
    end
    checks++; if (!ok) $display("[TB] FAIL bp_hold: valid %b data %h ready %b expected 1 2b4 0", resp_valid, resp_data, req_ready); else passes++;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("[TB] FAIL bp_no_same_cycle_accept: ready %b valid %b expected 1 0", req_ready, resp_valid); else passes++;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("[TB] FAIL bp_competing_accept: ready %b expected 0", req_ready); else passes++;
    wait_resp(got);
    checks++; if (!got || resp_data !== 11'h541) $display("[TB] FAIL bp_competing_data: got %h expected 541", resp_data); else passes++;
    handshake();
  endtask

`ifdef MAIN_MEMORY_WRITE_EN
  task automatic test_write_then_read();
    bit got;
    issue_req(11'h7FF, 1'b1, 11'h123);
    wait_resp(got);
    checks++; if (!got || resp_write !== 1'b1) $display("[TB] FAIL write_ack: resp_write %b expected 1", resp_write); else passes++;
    checks++; if (resp_data !== 11'h123) $display("[TB] FAIL write_echo: got %h expected 123", resp_data); else passes++;
    handshake();
    issue_req(11'h7FF, 1'b0, 11'h000);
    wait_resp(got);
    checks++; if (!got || resp_data !== 11'h123) $display("[TB] FAIL write_readback: got %h expected 123", resp_data); else passes++;
    checks++; if (resp_write !== 1'b0) $display("[TB] FAIL readback_resp_write: got %b expected 0", resp_write); else passes++;
    handshake();
  endtask
`else
  task automatic test_write_macro_off();
    bit got;
    issue_req(11'h005, 1'b1, 11'h3FF);
    wait_resp(got);
    checks++; if (!got || resp_write !== 1'b0) $display("[TB] FAIL nowr_resp_write: got %b expected 0", resp_write); else passes++;
    checks++; if (resp_data !== 11'h2BB) $display("[TB] FAIL nowr_resp_data: got %h expected 2bb", resp_data); else passes++;
    handshake();
  endtask
`endif

  task automatic test_reset_mid_wait();
    bit got;
    bit seen;
    issue_req(11'h7FF, 1'b0, 11'h000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) $display("[TB] FAIL midwait_dropped: resp_valid seen 1 expected 0"); else passes++;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL midwait_ready: got %b expected 1", req_ready); else passes++;
    issue_req(11'h7FF, 1'b0, 11'h000);
    wait_resp(got);
    checks++; if (!got || resp_data !== 11'h541) $display("[TB] FAIL midwait_reread: got %h expected 541", resp_data); else passes++;
    handshake();
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_write  = 1'b0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    test_reset();
    test_unwritten_read();
    test_backpressure();
`ifdef MAIN_MEMORY_WRITE_EN
    test_write_then_read();
`else
    test_write_macro_off();
`endif
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
